// File: rtl/i2c_master_defines.sv
// Shared bit-controller command codes and word-controller state encodings.
package i2c_master_defines;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_ACK   = 3'd5;
  localparam logic [2:0] ST_STOP  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_LOAD  = ST_LOAD,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ,
    S_ACK   = ST_ACK,
    S_STOP  = ST_STOP
  } word_state_t;

endpackage

// File: rtl/i2c_bit_counter.sv
// Down-counter tracking the remaining bits of a data phase.
module i2c_bit_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Clr,
  input  logic Load,
  input  logic Dec,
  output logic Zero
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over load; load presets to the last bit index.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    cnt <= '0;
    else if (Clr)  cnt <= '0;
    else if (Load) cnt <= CNT_W'(DATA_W - 1);
    else if (Dec)  cnt <= cnt - CNT_W'(1);
  end

  assign Zero = (cnt == '0);

endmodule

// File: rtl/i2c_master_word_ctrl.sv
// I2C master word controller: expands host commands into bit-controller
// command sequences, handles both ACK directions and optional NACK auto-stop.
//
// state | meaning
// IDLE  | waiting for a host command
// START | START condition on the bus
// LOAD  | one cycle to load the external shift register
// WRITE | shifting DATA_W bits out
// READ  | shifting DATA_W bits in
// ACK   | ACK bit: sample slave ACK (write) or drive Tx_ack (read)
// STOP  | STOP condition on the bus
module i2c_master_word_ctrl
  import i2c_master_defines::*;
#(
  parameter int DATA_W         = 8,
  parameter int NACK_AUTO_STOP = 0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Read,
  input  logic       Write,
  input  logic       Tx_ack,
  input  logic       I2C_al,
  input  logic       SR_sout,
  input  logic       Bit_ack,
  input  logic       Bit_rxd,
  output logic       Rx_ack,
  output logic       I2C_done,
  output logic       Al_lost,
  output logic       Busy,
  output logic       SR_load,
  output logic       SR_shift,
  output logic [3:0] Bit_cmd,
  output logic       Bit_txd
);

  localparam int CNT_W = $clog2(DATA_W);

  word_state_t state, state_nxt;
  logic [3:0]  cmd_nxt;
  logic        rx_ack_nxt, done_nxt, al_nxt, load_nxt;
  logic        is_wr, is_wr_nxt;
  logic        cnt_clr, cnt_load, cnt_dec, cnt_zero;

  i2c_bit_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_bit_cnt (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Clr  (cnt_clr),
    .Load (cnt_load),
    .Dec  (cnt_dec),
    .Zero (cnt_zero)
  );

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      Bit_cmd  <= I2C_CMD_NOP;
      Rx_ack   <= 1'b0;
      I2C_done <= 1'b0;
      Al_lost  <= 1'b0;
      SR_load  <= 1'b0;
      is_wr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      Bit_cmd  <= cmd_nxt;
      Rx_ack   <= rx_ack_nxt;
      I2C_done <= done_nxt;
      Al_lost  <= al_nxt;
      SR_load  <= load_nxt;
      is_wr    <= is_wr_nxt;
    end
  end

  // Next-state and next-output decode; arbitration loss overrides everything.
  always_comb begin
    state_nxt  = state;
    cmd_nxt    = Bit_cmd;
    rx_ack_nxt = Rx_ack;
    done_nxt   = 1'b0;
    al_nxt     = 1'b0;
    load_nxt   = 1'b0;
    is_wr_nxt  = is_wr;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (I2C_al) begin
      state_nxt = S_IDLE;
      cmd_nxt   = I2C_CMD_NOP;
      done_nxt  = 1'b1;
      al_nxt    = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (!I2C_done) begin
          if (Start) begin
            state_nxt = S_START;
            cmd_nxt   = I2C_CMD_START;
          end else if (Read) begin
            state_nxt = S_READ;
            cmd_nxt   = I2C_CMD_READ;
            cnt_load  = 1'b1;
            is_wr_nxt = 1'b0;
          end else if (Write) begin
            state_nxt = S_LOAD;
            load_nxt  = 1'b1;
          end else if (Stop) begin
            state_nxt = S_STOP;
            cmd_nxt   = I2C_CMD_STOP;
          end
        end
        S_START: if (Bit_ack) begin
          if (Read) begin
            state_nxt = S_READ;
            cmd_nxt   = I2C_CMD_READ;
            cnt_load  = 1'b1;
            is_wr_nxt = 1'b0;
          end else if (Write) begin
            state_nxt = S_LOAD;
            cmd_nxt   = I2C_CMD_NOP;
            load_nxt  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            cmd_nxt   = I2C_CMD_NOP;
            done_nxt  = 1'b1;
          end
        end
        S_LOAD: begin
          state_nxt = S_WRITE;
          cmd_nxt   = I2C_CMD_WRITE;
          cnt_load  = 1'b1;
          is_wr_nxt = 1'b1;
        end
        S_WRITE, S_READ: if (Bit_ack) begin
          if (cnt_zero) begin
            state_nxt = S_ACK;
            cmd_nxt   = (state == S_WRITE) ? I2C_CMD_READ : I2C_CMD_WRITE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_ACK: if (Bit_ack) begin
          if (is_wr) rx_ack_nxt = Bit_rxd;
          if (Stop || ((NACK_AUTO_STOP != 0) && is_wr && Bit_rxd)) begin
            state_nxt = S_STOP;
            cmd_nxt   = I2C_CMD_STOP;
          end else begin
            state_nxt = S_IDLE;
            cmd_nxt   = I2C_CMD_NOP;
            done_nxt  = 1'b1;
          end
        end
        S_STOP: if (Bit_ack) begin
          state_nxt = S_IDLE;
          cmd_nxt   = I2C_CMD_NOP;
          done_nxt  = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Shift strobe and transmit-bit select follow the current phase.
  always_comb begin
    SR_shift = Bit_ack && !I2C_al && (state == S_WRITE || state == S_READ);
    Bit_txd  = 1'b0;
    if (state == S_WRITE)             Bit_txd = SR_sout;
    else if (state == S_ACK && !is_wr) Bit_txd = Tx_ack;
  end

  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_master_word_ctrl.sv
// Bench for i2c_master_word_ctrl: four instances cover DATA_W 8/12/2 and
// NACK auto-stop; the bench plays the bit controller and shift register.
module tb_i2c_master_word_ctrl;
  import i2c_master_defines::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start, stop, rd, wr, tx_ack, i2c_al, sout, bit_ack, bit_rxd;
  logic [3:0] rx_ack, done, al_lost, busy, sr_load, sr_shift, txd;
  logic [3:0] bc [4];
  logic [31:0] sr [4];
  logic [31:0] wdata [4];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_master_word_ctrl #(.DATA_W(8), .NACK_AUTO_STOP(0)) u0 (
    .Clk(clk), .Rst_n(rst_n), .Start(start[0]), .Stop(stop[0]), .Read(rd[0]),
    .Write(wr[0]), .Tx_ack(tx_ack[0]), .I2C_al(i2c_al[0]), .SR_sout(sout[0]),
    .Bit_ack(bit_ack[0]), .Bit_rxd(bit_rxd[0]), .Rx_ack(rx_ack[0]), .I2C_done(done[0]),
    .Al_lost(al_lost[0]), .Busy(busy[0]), .SR_load(sr_load[0]), .SR_shift(sr_shift[0]),
    .Bit_cmd(bc[0]), .Bit_txd(txd[0]));
  i2c_master_word_ctrl #(.DATA_W(8), .NACK_AUTO_STOP(1)) u1 (
    .Clk(clk), .Rst_n(rst_n), .Start(start[1]), .Stop(stop[1]), .Read(rd[1]),
    .Write(wr[1]), .Tx_ack(tx_ack[1]), .I2C_al(i2c_al[1]), .SR_sout(sout[1]),
    .Bit_ack(bit_ack[1]), .Bit_rxd(bit_rxd[1]), .Rx_ack(rx_ack[1]), .I2C_done(done[1]),
    .Al_lost(al_lost[1]), .Busy(busy[1]), .SR_load(sr_load[1]), .SR_shift(sr_shift[1]),
    .Bit_cmd(bc[1]), .Bit_txd(txd[1]));
  i2c_master_word_ctrl #(.DATA_W(12), .NACK_AUTO_STOP(0)) u2 (
    .Clk(clk), .Rst_n(rst_n), .Start(start[2]), .Stop(stop[2]), .Read(rd[2]),
    .Write(wr[2]), .Tx_ack(tx_ack[2]), .I2C_al(i2c_al[2]), .SR_sout(sout[2]),
    .Bit_ack(bit_ack[2]), .Bit_rxd(bit_rxd[2]), .Rx_ack(rx_ack[2]), .I2C_done(done[2]),
    .Al_lost(al_lost[2]), .Busy(busy[2]), .SR_load(sr_load[2]), .SR_shift(sr_shift[2]),
    .Bit_cmd(bc[2]), .Bit_txd(txd[2]));
  i2c_master_word_ctrl #(.DATA_W(2), .NACK_AUTO_STOP(0)) u3 (
    .Clk(clk), .Rst_n(rst_n), .Start(start[3]), .Stop(stop[3]), .Read(rd[3]),
    .Write(wr[3]), .Tx_ack(tx_ack[3]), .I2C_al(i2c_al[3]), .SR_sout(sout[3]),
    .Bit_ack(bit_ack[3]), .Bit_rxd(bit_rxd[3]), .Rx_ack(rx_ack[3]), .I2C_done(done[3]),
    .Al_lost(al_lost[3]), .Busy(busy[3]), .SR_load(sr_load[3]), .SR_shift(sr_shift[3]),
    .Bit_cmd(bc[3]), .Bit_txd(txd[3]));

  // External shift-register model, MSB first.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (sr_load[d])       sr[d] <= wdata[d];
      else if (sr_shift[d]) sr[d] <= sr[d] << 1;
    end
  end
  assign sout[0] = sr[0][7];
  assign sout[1] = sr[1][7];
  assign sout[2] = sr[2][11];
  assign sout[3] = sr[3][1];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One bit-controller handshake: check command held, pulse Bit_ack.
  task automatic ack(int d, logic rxd, logic [3:0] ecmd, logic etxd, logic eshift, string nm);
    chk({nm, " cmd"}, 32'(bc[d]), 32'(ecmd));
    bit_ack[d] = 1'b1;
    bit_rxd[d] = rxd;
    #1;
    chk({nm, " txd"}, 32'(txd[d]), 32'(etxd));
    chk({nm, " shift"}, 32'(sr_shift[d]), 32'(eshift));
    @(negedge clk);
    bit_ack[d] = 1'b0;
    bit_rxd[d] = 1'b0;
  endtask

  // Write without START on instance d, n data bits, slave answers nack.
  task automatic run_write(int d, int n, logic [31:0] pat, logic nack, logic exp_stop);
    wdata[d] = pat;
    wr[d] = 1'b1;
    @(negedge clk);
    chk("wr load", 32'(sr_load[d]), 32'd1);
    chk("wr load cmd", 32'(bc[d]), 32'(I2C_CMD_NOP));
    @(negedge clk);
    chk("wr load drop", 32'(sr_load[d]), 32'd0);
    for (int i = 0; i < n; i++) ack(d, 1'b0, I2C_CMD_WRITE, pat[n-1-i], 1'b1, "wr bit");
    ack(d, nack, I2C_CMD_READ, 1'b0, 1'b0, "wr ack");
    if (exp_stop) begin
      chk("auto stop done", 32'(done[d]), 32'd0);
      ack(d, 1'b0, I2C_CMD_STOP, 1'b0, 1'b0, "auto stop");
    end
    chk("wr done", 32'(done[d]), 32'd1);
    chk("wr rx_ack", 32'(rx_ack[d]), 32'(nack));
    chk("wr end cmd", 32'(bc[d]), 32'(I2C_CMD_NOP));
    chk("wr end busy", 32'(busy[d]), 32'd0);
    @(negedge clk);
    wr[d] = 1'b0;
    chk("wr done pulse", 32'(done[d]), 32'd0);
    chk("wr no restart", 32'(busy[d]), 32'd0);
  endtask

  typedef struct {
    logic       st, sp, r, w;
    logic [3:0] cmd;
    logic       load, bsy;
  } vec_t;
  vec_t tbl [7];

  initial begin
    rst_n = 1'b0;
    {start, stop, rd, wr, tx_ack, i2c_al, bit_ack, bit_rxd} = '0;
    for (int d = 0; d < 4; d++) begin
      wdata[d] = '0;
    end
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, I2C_CMD_NOP,   1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, I2C_CMD_START, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, I2C_CMD_READ,  1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, I2C_CMD_NOP,   1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, I2C_CMD_STOP,  1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, I2C_CMD_START, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 0,    I2C_CMD_READ,  1'b0, 1'b1};
    do_reset();

    // Reset values.
    chk("rst cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst done", 32'(done[0]), 32'd0);
    chk("rst al", 32'(al_lost[0]), 32'd0);
    chk("rst load", 32'(sr_load[0]), 32'd0);
    chk("rst rx_ack", 32'(rx_ack[0]), 32'd0);

    // IDLE command priority, one step from reset.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      start[0] = tbl[v].st; stop[0] = tbl[v].sp; rd[0] = tbl[v].r; wr[0] = tbl[v].w;
      @(negedge clk);
      chk($sformatf("prio%0d cmd", v), 32'(bc[0]), 32'(tbl[v].cmd));
      chk($sformatf("prio%0d load", v), 32'(sr_load[0]), 32'(tbl[v].load));
      chk($sformatf("prio%0d busy", v), 32'(busy[0]), 32'(tbl[v].bsy));
      {start[0], stop[0], rd[0], wr[0]} = '0;
    end
    do_reset();

    // START + write 0xA5, slave ACK; commands held through the done cycle.
    wdata[0] = 32'hA5;
    start[0] = 1'b1; wr[0] = 1'b1;
    @(negedge clk);
    ack(0, 1'b0, I2C_CMD_START, 1'b0, 1'b0, "sw start");
    chk("sw load", 32'(sr_load[0]), 32'd1);
    chk("sw load cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    @(negedge clk);
    for (int i = 0; i < 8; i++) ack(0, 1'b0, I2C_CMD_WRITE, wdata[0][7-i], 1'b1, "sw bit");
    ack(0, 1'b0, I2C_CMD_READ, 1'b0, 1'b0, "sw ack");
    chk("sw done", 32'(done[0]), 32'd1);
    chk("sw rx_ack", 32'(rx_ack[0]), 32'd0);
    chk("sw end cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    @(negedge clk);
    chk("sw done pulse", 32'(done[0]), 32'd0);
    chk("sw held no restart", 32'(busy[0]), 32'd0);
    chk("sw held cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    start[0] = 1'b0; wr[0] = 1'b0;

    // Read with Tx_ack=1 then Stop; Rx_ack must not change after a read.
    rd[0] = 1'b1; stop[0] = 1'b1; tx_ack[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) ack(0, i[0], I2C_CMD_READ, 1'b0, 1'b1, "rd bit");
    ack(0, 1'b1, I2C_CMD_WRITE, 1'b1, 1'b0, "rd ack");
    chk("rd rx_ack kept", 32'(rx_ack[0]), 32'd0);
    chk("rd stop no done", 32'(done[0]), 32'd0);
    ack(0, 1'b0, I2C_CMD_STOP, 1'b0, 1'b0, "rd stop");
    chk("rd done", 32'(done[0]), 32'd1);
    chk("rd end cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    rd[0] = 1'b0; stop[0] = 1'b0; tx_ack[0] = 1'b0;
    @(negedge clk);
    chk("rd done pulse", 32'(done[0]), 32'd0);

    // Arbitration lost on the 4th data bit, then a clean 8-bit write.
    wdata[0] = 32'hFF;
    wr[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) ack(0, 1'b0, I2C_CMD_WRITE, 1'b1, 1'b1, "al bit");
    i2c_al[0] = 1'b1;
    ack(0, 1'b0, I2C_CMD_WRITE, 1'b1, 1'b0, "al 4th");
    i2c_al[0] = 1'b0;
    chk("al busy", 32'(busy[0]), 32'd0);
    chk("al cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    chk("al done", 32'(done[0]), 32'd1);
    chk("al lost", 32'(al_lost[0]), 32'd1);
    chk("al load", 32'(sr_load[0]), 32'd0);
    wr[0] = 1'b0;
    @(negedge clk);
    chk("al lost pulse", 32'(al_lost[0]), 32'd0);
    run_write(0, 8, 32'h3C, 1'b0, 1'b0);

    // NACK: without and with auto-stop.
    run_write(0, 8, 32'h96, 1'b1, 1'b0);
    run_write(1, 8, 32'h5A, 1'b1, 1'b1);

    // Data-width extremes.
    run_write(2, 12, 32'hB5A, 1'b0, 1'b0);
    run_write(3, 2, 32'h2, 1'b0, 1'b0);

    // Reset in the middle of a read.
    chk("pre rst rx_ack", 32'(rx_ack[0]), 32'd1);
    rd[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) ack(0, 1'b0, I2C_CMD_READ, 1'b0, 1'b1, "mid rd");
    rst_n = 1'b0;
    #1;
    chk("mid rst cmd", 32'(bc[0]), 32'(I2C_CMD_NOP));
    chk("mid rst busy", 32'(busy[0]), 32'd0);
    chk("mid rst rx_ack", 32'(rx_ack[0]), 32'd0);
    chk("mid rst done", 32'(done[0]), 32'd0);
    rd[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst idle", 32'(busy[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
